// File: rtl/axis_route_demux.sv
// Packet-locked AXI-Stream output demultiplexer for one mesh NoC router port.
// Routes a header beat XY or YX, holds that channel until TLAST, drops the rest.
module axis_route_demux #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int CHANNEL_NUMBER = 5,
    parameter int MAX_ROUTERS_X  = 4,
    parameter int MAX_ROUTERS_Y  = 4,
    parameter int ROUTER_X       = 0,
    parameter int ROUTER_Y       = 0,
    parameter int ROUTING_MODE   = 0,
    parameter int ROUTING_HEADER = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                in_tvalid_i,
    output logic                                in_tready_o,
    input  logic [DATA_WIDTH-1:0]               in_tdata_i,
    input  logic [ID_WIDTH-1:0]                 in_tid_i,
    input  logic                                in_tlast_i,
    output logic [CHANNEL_NUMBER-1:0]           out_tvalid_o,
    input  logic [CHANNEL_NUMBER-1:0]           out_tready_i,
    output logic [DATA_WIDTH-1:0]               out_tdata_o,
    output logic [ID_WIDTH-1:0]                 out_tid_o,
    output logic                                out_tlast_o,
    output logic [CHANNEL_NUMBER*CNT_WIDTH-1:0] pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]                drop_cnt_o
);

    localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
    localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;

    localparam logic [XW:0]   X_LIM  = (XW + 1)'(MAX_ROUTERS_X);
    localparam logic [YW:0]   Y_LIM  = (YW + 1)'(MAX_ROUTERS_Y);
    localparam logic [XW-1:0] X_HOME = XW'(ROUTER_X);
    localparam logic [YW-1:0] Y_HOME = YW'(ROUTER_Y);

    localparam logic [ID_WIDTH-1:0]  HDR_ID  = ID_WIDTH'(ROUTING_HEADER);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [2:0] CH_LOCAL = 3'd0;
    localparam logic [2:0] CH_NORTH = 3'd1;
    localparam logic [2:0] CH_SOUTH = 3'd2;
    localparam logic [2:0] CH_EAST  = 3'd3;
    localparam logic [2:0] CH_WEST  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           lock_q, lock_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q [CHANNEL_NUMBER];
    logic [CNT_WIDTH-1:0] pkt_cnt_d [CHANNEL_NUMBER];
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [XW-1:0]             tx;
    logic [YW-1:0]             ty;
    logic                      x_gt, x_lt, y_gt, y_lt;
    logic                      out_of_range;
    logic                      is_hdr;
    logic [2:0]                route;
    logic [CHANNEL_NUMBER-1:0] pkt_inc;
    logic                      drop_inc;

    assign tx = in_tdata_i[XW-1:0];
    assign ty = in_tdata_i[XW+YW-1:XW];

    assign x_gt = tx > X_HOME;
    assign x_lt = tx < X_HOME;
    assign y_gt = ty > Y_HOME;
    assign y_lt = ty < Y_HOME;

    assign out_of_range = ({1'b0, tx} >= X_LIM) || ({1'b0, ty} >= Y_LIM);
    assign is_hdr       = in_tid_i == HDR_ID;

    // Dimension order: the first unresolved axis picks the port.
    always_comb begin
        route = CH_LOCAL;
        if (ROUTING_MODE == 0) begin
            if (x_gt) begin
                route = CH_EAST;
            end else if (x_lt) begin
                route = CH_WEST;
            end else if (y_gt) begin
                route = CH_NORTH;
            end else if (y_lt) begin
                route = CH_SOUTH;
            end
        end else begin
            if (y_gt) begin
                route = CH_NORTH;
            end else if (y_lt) begin
                route = CH_SOUTH;
            end else if (x_gt) begin
                route = CH_EAST;
            end else if (x_lt) begin
                route = CH_WEST;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        in_tready_o  = 1'b0;
        out_tvalid_o = '0;
        pkt_inc      = '0;
        drop_inc     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_tvalid_i) begin
                    if (!is_hdr) begin
                        in_tready_o = 1'b1;
                        drop_inc    = 1'b1;
                    end else if (out_of_range) begin
                        in_tready_o = 1'b1;
                        drop_inc    = 1'b1;
                        if (!in_tlast_i) begin
                            state_d = S_DROP;
                        end
                    end else begin
                        out_tvalid_o[route] = 1'b1;
                        in_tready_o         = out_tready_i[route];
                        if (out_tready_i[route]) begin
                            lock_d         = route;
                            pkt_inc[route] = 1'b1;
                            if (!in_tlast_i) begin
                                state_d = S_FWD;
                            end
                        end
                    end
                end
            end
            // Mid-packet the TID is payload, even if it equals the header ID.
            S_FWD: begin
                if (in_tvalid_i) begin
                    out_tvalid_o[lock_q] = 1'b1;
                    in_tready_o          = out_tready_i[lock_q];
                    if (out_tready_i[lock_q] && in_tlast_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (in_tvalid_i) begin
                    in_tready_o = 1'b1;
                    drop_inc    = 1'b1;
                    if (in_tlast_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            pkt_cnt_d[c] = pkt_cnt_q[c];
            if (pkt_inc[c] && (pkt_cnt_q[c] != CNT_MAX)) begin
                pkt_cnt_d[c] = pkt_cnt_q[c] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            lock_q     <= CH_LOCAL;
            drop_cnt_q <= '0;
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                pkt_cnt_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            drop_cnt_q <= drop_cnt_d;
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                pkt_cnt_q[c] <= pkt_cnt_d[c];
            end
        end
    end

    for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_cnt
        assign pkt_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
    end

    assign drop_cnt_o  = drop_cnt_q;
    assign out_tdata_o = in_tdata_i;
    assign out_tid_o   = in_tid_i;
    assign out_tlast_o = in_tlast_i;

endmodule

// File: tb/tb_axis_route_demux.sv
// Bench for axis_route_demux: vector table, corner sequences, random vs model.
// Instances: 0 XY 4x4, 1 YX 4x4, 2 XY 3x3, 3 XY 4x4 with 2-bit counters.
module tb_axis_route_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        vld  [4];
    logic [31:0] dat  [4];
    logic [3:0]  tid  [4];
    logic        lst  [4];
    logic [4:0]  ordy [4];
    logic        rdy  [4];
    logic [4:0]  ovld [4];
    logic [31:0] odat [4];
    logic [3:0]  otid [4];
    logic        olst [4];
    logic [79:0] pcnt [3];
    logic [15:0] dcnt [3];
    logic [9:0]  pcnt_s;
    logic [1:0]  dcnt_s;

    logic [4:0]  s_vld;
    logic        s_rdy;
    logic [31:0] s_dat;
    logic [3:0]  s_tid;
    logic        s_lst;

    int n_tests = 0;
    int n_fail  = 0;

    axis_route_demux #(
        .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1),
        .ROUTING_MODE(0), .CNT_WIDTH(16)
    ) u_xy (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_tvalid_i(vld[0]), .in_tready_o(rdy[0]), .in_tdata_i(dat[0]),
        .in_tid_i(tid[0]), .in_tlast_i(lst[0]),
        .out_tvalid_o(ovld[0]), .out_tready_i(ordy[0]), .out_tdata_o(odat[0]),
        .out_tid_o(otid[0]), .out_tlast_o(olst[0]),
        .pkt_cnt_o(pcnt[0]), .drop_cnt_o(dcnt[0])
    );

    axis_route_demux #(
        .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1),
        .ROUTING_MODE(1), .CNT_WIDTH(16)
    ) u_yx (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_tvalid_i(vld[1]), .in_tready_o(rdy[1]), .in_tdata_i(dat[1]),
        .in_tid_i(tid[1]), .in_tlast_i(lst[1]),
        .out_tvalid_o(ovld[1]), .out_tready_i(ordy[1]), .out_tdata_o(odat[1]),
        .out_tid_o(otid[1]), .out_tlast_o(olst[1]),
        .pkt_cnt_o(pcnt[1]), .drop_cnt_o(dcnt[1])
    );

    axis_route_demux #(
        .MAX_ROUTERS_X(3), .MAX_ROUTERS_Y(3), .ROUTER_X(1), .ROUTER_Y(1),
        .ROUTING_MODE(0), .CNT_WIDTH(16)
    ) u_oor (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_tvalid_i(vld[2]), .in_tready_o(rdy[2]), .in_tdata_i(dat[2]),
        .in_tid_i(tid[2]), .in_tlast_i(lst[2]),
        .out_tvalid_o(ovld[2]), .out_tready_i(ordy[2]), .out_tdata_o(odat[2]),
        .out_tid_o(otid[2]), .out_tlast_o(olst[2]),
        .pkt_cnt_o(pcnt[2]), .drop_cnt_o(dcnt[2])
    );

    axis_route_demux #(
        .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1),
        .ROUTING_MODE(0), .CNT_WIDTH(2)
    ) u_sat (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_tvalid_i(vld[3]), .in_tready_o(rdy[3]), .in_tdata_i(dat[3]),
        .in_tid_i(tid[3]), .in_tlast_i(lst[3]),
        .out_tvalid_o(ovld[3]), .out_tready_i(ordy[3]), .out_tdata_o(odat[3]),
        .out_tid_o(otid[3]), .out_tlast_o(olst[3]),
        .pkt_cnt_o(pcnt_s), .drop_cnt_o(dcnt_s)
    );

    typedef struct {
        logic        v;
        logic [31:0] x;
        logic [3:0]  id;
        logic        l;
        logic [4:0]  r;
        logic [4:0]  ev;
        logic        er;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pkt(input int d, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
        chk("pkt_local", int'(pcnt[d][0  +: 16]), e0);
        chk("pkt_north", int'(pcnt[d][16 +: 16]), e1);
        chk("pkt_south", int'(pcnt[d][32 +: 16]), e2);
        chk("pkt_east",  int'(pcnt[d][48 +: 16]), e3);
        chk("pkt_west",  int'(pcnt[d][64 +: 16]), e4);
    endtask

    // Drive one cycle, sample mid-cycle, return just after the clock edge.
    task automatic step(input int d, input logic v, input logic [31:0] x,
                        input logic [3:0] id, input logic l, input logic [4:0] r);
        vld[d] = v; dat[d] = x; tid[d] = id; lst[d] = l; ordy[d] = r;
        @(negedge clk);
        s_vld = ovld[d]; s_rdy = rdy[d]; s_dat = odat[d];
        s_tid = otid[d]; s_lst = olst[d];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 4; k++) vld[k] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference routing: first non-zero offset in the chosen axis order.
    function automatic int route_of(input int mode, input int tx, input int ty);
        int xch;
        int ych;
        xch = (tx > 1) ? 3 : ((tx < 1) ? 4 : 0);
        ych = (ty > 1) ? 1 : ((ty < 1) ? 2 : 0);
        if (mode == 0) return (xch != 0) ? xch : ych;
        return (ych != 0) ? ych : xch;
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] x, input logic [3:0] id,
                                input logic l, input logic [4:0] r,
                                input logic [4:0] ev, input logic er);
        vec_t t;
        t.v = v; t.x = x; t.id = id; t.l = l; t.r = r; t.ev = ev; t.er = er;
        return t;
    endfunction

    int md [3] = '{0, 1, 0};
    int mx [3] = '{4, 4, 3};
    int my [3] = '{4, 4, 3};

    initial begin
        int east_hs;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0; dat[k] = '0; tid[k] = '0; lst[k] = 1'b0; ordy[k] = '0;
        end
        do_reset();

        // Router (1,1), XY: x = data[1:0], y = data[3:2], header TID 0.
        tbl[0]  = mk(0, 32'h0,         4'h0, 0, 5'h1F, 5'h00, 0);
        tbl[1]  = mk(1, 32'h3,         4'h0, 0, 5'h1F, 5'h08, 1);
        tbl[2]  = mk(1, 32'hDEADBEEF,  4'h5, 0, 5'h1F, 5'h08, 1);
        tbl[3]  = mk(1, 32'h12345678,  4'h2, 1, 5'h1F, 5'h08, 1);
        tbl[4]  = mk(1, 32'h5,         4'h0, 1, 5'h1F, 5'h01, 1);
        tbl[5]  = mk(1, 32'h4,         4'h0, 1, 5'h1F, 5'h10, 1);
        tbl[6]  = mk(1, 32'hD,         4'h0, 1, 5'h1F, 5'h02, 1);
        tbl[7]  = mk(1, 32'h1,         4'h0, 1, 5'h1B, 5'h04, 0);
        tbl[8]  = mk(1, 32'h1,         4'h0, 1, 5'h04, 5'h04, 1);
        tbl[9]  = mk(1, 32'h7,         4'h3, 0, 5'h1F, 5'h00, 1);
        tbl[10] = mk(1, 32'hA,         4'h0, 0, 5'h17, 5'h08, 0);
        tbl[11] = mk(1, 32'hA,         4'h0, 0, 5'h08, 5'h08, 1);
        tbl[12] = mk(1, 32'h5,         4'h0, 1, 5'h1F, 5'h08, 1);
        tbl[13] = mk(1, 32'h5,         4'h0, 1, 5'h00, 5'h01, 0);
        tbl[14] = mk(1, 32'h5,         4'h0, 1, 5'h01, 5'h01, 1);

        chk_pkt(0, 0, 0, 0, 0, 0);
        chk("reset_drop", int'(dcnt[0]), 0);

        for (int i = 0; i < 15; i++) begin
            step(0, tbl[i].v, tbl[i].x, tbl[i].id, tbl[i].l, tbl[i].r);
            chk($sformatf("tbl%0d_vld", i), int'(s_vld), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_rdy", i), int'(s_rdy), int'(tbl[i].er));
            chk($sformatf("tbl%0d_dat", i), int'(s_dat), int'(tbl[i].x));
            chk($sformatf("tbl%0d_tid", i), int'(s_tid), int'(tbl[i].id));
            chk($sformatf("tbl%0d_lst", i), int'(s_lst), int'(tbl[i].l));
        end
        vld[0] = 1'b0;
        chk_pkt(0, 2, 1, 1, 2, 1);
        chk("tbl_drop", int'(dcnt[0]), 1);

        // Locked EAST packet stalled 5 cycles on a header-TID body beat.
        east_hs = 0;
        step(0, 1, 32'h3, 4'h0, 0, 5'h1F);
        chk("bp_hdr_vld", int'(s_vld), 8);
        if (s_vld[3] && s_rdy) east_hs++;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'hA5, 4'h0, 0, 5'h17);
            chk("bp_stall_rdy", int'(s_rdy), 0);
            chk("bp_stall_vld", int'(s_vld), 8);
            if (s_vld[3] && s_rdy) east_hs++;
        end
        step(0, 1, 32'hA5, 4'h0, 0, 5'h1F);
        chk("bp_go_vld", int'(s_vld), 8);
        if (s_vld[3] && s_rdy) east_hs++;
        step(0, 1, 32'h77, 4'h4, 1, 5'h1F);
        chk("bp_last_vld", int'(s_vld), 8);
        if (s_vld[3] && s_rdy) east_hs++;
        vld[0] = 1'b0;
        chk("bp_east_beats", east_hs, 3);
        chk_pkt(0, 2, 1, 1, 3, 1);

        // YX: x=3,y=0 from (1,1) resolves Y first, so SOUTH.
        step(1, 1, 32'h3, 4'h0, 0, 5'h1F);
        chk("yx_hdr_vld", int'(s_vld), 4);
        step(1, 1, 32'h11, 4'h6, 0, 5'h1F);
        chk("yx_b2_vld", int'(s_vld), 4);
        step(1, 1, 32'h22, 4'h7, 1, 5'h1F);
        chk("yx_b3_vld", int'(s_vld), 4);
        step(1, 1, 32'h33, 4'h1, 0, 5'h1F);
        chk("yx_stray_vld", int'(s_vld), 0);
        chk("yx_stray_rdy", int'(s_rdy), 1);
        vld[1] = 1'b0;
        chk_pkt(1, 0, 0, 1, 0, 0);
        chk("yx_drop", int'(dcnt[1]), 1);

        // 3x3 mesh: x=3 is beyond the edge; whole 4-beat packet dropped.
        step(2, 1, 32'h3, 4'h0, 0, 5'h00);
        chk("oor_b1_vld", int'(s_vld), 0);
        chk("oor_b1_rdy", int'(s_rdy), 1);
        for (int i = 0; i < 3; i++) begin
            step(2, 1, 32'h6, 4'h0, (i == 2), 5'h00);
            chk("oor_body_vld", int'(s_vld), 0);
            chk("oor_body_rdy", int'(s_rdy), 1);
        end
        chk("oor_drop4", int'(dcnt[2]), 4);
        step(2, 1, 32'h6, 4'h0, 1, 5'h1F);
        chk("oor_next_vld", int'(s_vld), 8);
        step(2, 1, 32'hC, 4'h0, 1, 5'h1F);
        chk("oor_y_vld", int'(s_vld), 0);
        vld[2] = 1'b0;
        chk("oor_drop5", int'(dcnt[2]), 5);
        chk_pkt(2, 0, 0, 0, 1, 0);

        // Reset after beat 2 of 4: tail beats become counted strays.
        step(0, 1, 32'h3, 4'h0, 0, 5'h1F);
        step(0, 1, 32'h44, 4'h1, 0, 5'h1F);
        vld[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_pkt(0, 0, 0, 0, 0, 0);
        chk("rst_drop", int'(dcnt[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 32'h55, 4'h1, 0, 5'h1F);
        chk("rst_b3_vld", int'(s_vld), 0);
        chk("rst_b3_rdy", int'(s_rdy), 1);
        step(0, 1, 32'h66, 4'h1, 1, 5'h1F);
        chk("rst_b4_vld", int'(s_vld), 0);
        vld[0] = 1'b0;
        chk("rst_drop2", int'(dcnt[0]), 2);

        // 2-bit counters saturate at 3.
        for (int i = 0; i < 5; i++) begin
            step(3, 1, 32'h5, 4'h0, 1, 5'h1F);
            chk("sat_local_vld", int'(s_vld), 1);
        end
        for (int i = 0; i < 5; i++) step(3, 1, 32'h9, 4'h2, 0, 5'h1F);
        vld[3] = 1'b0;
        chk("sat_pkt_local", int'(pcnt_s[1:0]), 3);
        chk("sat_pkt_rest", int'(pcnt_s[9:2]), 0);
        chk("sat_drop", int'(dcnt_s), 3);

        do_reset();
        for (int d = 0; d < 3; d++) begin
            int mid, dest, ed, tx, ty, ch;
            int ep [5];
            logic pend, v, l, er, oor;
            logic [31:0] x;
            logic [3:0] id;
            logic [4:0] r, ev;
            mid = 0; dest = 0; ed = 0; pend = 1'b0;
            v = 1'b0; l = 1'b0; x = '0; id = '0;
            for (int c = 0; c < 5; c++) ep[c] = 0;
            for (int i = 0; i < 400; i++) begin
                if (!pend) begin
                    v  = ($urandom_range(0, 3) != 0);
                    x  = $urandom;
                    id = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    l  = ($urandom_range(0, 2) == 0);
                end
                r   = 5'($urandom);
                tx  = int'(x[1:0]);
                ty  = int'(x[3:2]);
                oor = (tx >= mx[d]) || (ty >= my[d]);
                ch  = route_of(md[d], tx, ty);
                ev  = '0;
                er  = 1'b0;
                if (v) begin
                    if (mid == 0 && id == 4'h0 && !oor) begin
                        ev = 5'(1 << ch);
                        er = r[ch];
                    end else if (mid == 0 || dest < 0) begin
                        er = 1'b1;
                    end else begin
                        ev = 5'(1 << dest);
                        er = r[dest];
                    end
                end
                step(d, v, x, id, l, r);
                chk("rnd_vld", int'(s_vld), int'(ev));
                chk("rnd_rdy", int'(s_rdy), int'(er));
                if (v && er) begin
                    if (mid == 0) begin
                        if (id != 4'h0 || oor) ed++;
                        else ep[ch]++;
                        if (id == 4'h0 && !l) begin
                            mid  = 1;
                            dest = oor ? -1 : ch;
                        end
                    end else begin
                        if (dest < 0) ed++;
                        if (l) mid = 0;
                    end
                end
                pend = v && !s_rdy;
            end
            vld[d] = 1'b0;
            chk_pkt(d, ep[0], ep[1], ep[2], ep[3], ep[4]);
            chk("rnd_drop", int'(dcnt[d]), ed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected $finish before it");
        $fatal(1);
    end

endmodule
